// File: rtl/fetch_sequencer.sv
// Program counter and instruction fetch stage feeding the 8-bit ALU.
// Fetches one instruction per step over a req/ack handshake, holds it while
// the execute side works, then computes the next PC from the ALU's jump
// flag and relative offset. Self-jumps halt; ack timeouts raise fetch_err.
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] instr,
  output logic [7:0] pc,
  output logic       instr_valid,
  input  logic       exec_done,
  input  logic [7:0] jump,
  input  logic [7:0] alu_out,
  output logic       link_we,
  output logic [7:0] link_data,
  output logic       halted,
  output logic       fetch_err
);

  localparam int unsigned   CW     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(ACK_TIMEOUT);
  localparam logic          TO_EN  = (ACK_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t state_r, state_nxt_s;

  logic [7:0]    pc_r, pc_nxt_s;
  logic [7:0]    instr_r, instr_nxt_s;
  logic          req_r, req_nxt_s;
  logic          ivalid_r, ivalid_nxt_s;
  logic          link_we_r, link_we_nxt_s;
  logic [7:0]    link_data_r, link_data_nxt_s;
  logic          halted_r, halted_nxt_s;
  logic          err_r, err_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [7:0]    jump_r, jump_nxt_s;
  logic [7:0]    alu_r, alu_nxt_s;

  logic [CW-1:0] cnt_inc_s;
  logic          timeout_s;
  logic          taken_s;
  logic [7:0]    pc_inc_s;
  logic [7:0]    imm_sext_s;
  logic [7:0]    target_s;
  logic          halt_s;
  logic          jal_now_s;

  assign cnt_inc_s  = cnt_r + CW'(1);
  assign timeout_s  = TO_EN && (cnt_inc_s == TO_LIM);
  assign taken_s    = (jump_r == 8'hFF);
  assign pc_inc_s   = pc_r + 8'd1;
  assign imm_sext_s = {{4{instr_r[3]}}, instr_r[3:0]};
  assign halt_s     = taken_s && (target_s == pc_r);
  // Link decision uses the live ALU flag on the exec_done cycle so link_we
  // can be registered high for exactly the UPDATE cycle.
  assign jal_now_s  = (instr_r[7:4] == 4'b1001) && (jump == 8'hFF);

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_valid = ivalid_r;
  assign link_we     = link_we_r;
  assign link_data   = link_data_r;
  assign halted      = halted_r;
  assign fetch_err   = err_r;

  // Branch target selection from the latched ALU results and opcode.
  always_comb begin
    target_s = pc_inc_s;
    if (taken_s) begin
      case (instr_r[7:4])
        4'b1000, 4'b1001: target_s = pc_inc_s + alu_r;
        4'b1100, 4'b1101: target_s = pc_inc_s + imm_sext_s;
        default:          target_s = pc_inc_s;
      endcase
    end else begin
      target_s = pc_inc_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   state_nxt_s = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_nxt_s = S_EXEC;
        end else if (timeout_s) begin
          state_nxt_s = S_ERROR;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_nxt_s = S_UPDATE;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_UPDATE: begin
        if (halt_s) begin
          state_nxt_s = S_HALT;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_HALT:   state_nxt_s = S_HALT;
      S_ERROR:  state_nxt_s = S_ERROR;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and datapath.
  always_comb begin
    pc_nxt_s        = pc_r;
    instr_nxt_s     = instr_r;
    req_nxt_s       = req_r;
    ivalid_nxt_s    = ivalid_r;
    link_we_nxt_s   = 1'b0;
    link_data_nxt_s = link_data_r;
    halted_nxt_s    = halted_r;
    err_nxt_s       = err_r;
    cnt_nxt_s       = cnt_r;
    jump_nxt_s      = jump_r;
    alu_nxt_s       = alu_r;
    case (state_r)
      S_IDLE: begin
        req_nxt_s = 1'b1;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_nxt_s  = imem_data;
          req_nxt_s    = 1'b0;
          cnt_nxt_s    = '0;
          ivalid_nxt_s = 1'b1;
        end else if (timeout_s) begin
          req_nxt_s = 1'b0;
          err_nxt_s = 1'b1;
          cnt_nxt_s = cnt_inc_s;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          jump_nxt_s    = jump;
          alu_nxt_s     = alu_out;
          ivalid_nxt_s  = 1'b0;
          link_we_nxt_s = jal_now_s;
          if (jal_now_s) begin
            link_data_nxt_s = pc_inc_s;
          end else begin
            link_data_nxt_s = link_data_r;
          end
        end else begin
          ivalid_nxt_s = 1'b1;
        end
      end
      S_UPDATE: begin
        if (halt_s) begin
          halted_nxt_s = 1'b1;
        end else begin
          pc_nxt_s  = target_s;
          req_nxt_s = 1'b1;
        end
      end
      S_HALT:  req_nxt_s = 1'b0;
      S_ERROR: req_nxt_s = 1'b0;
      default: req_nxt_s = 1'b0;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= RESET_PC;
      instr_r     <= 8'h00;
      req_r       <= 1'b0;
      ivalid_r    <= 1'b0;
      link_we_r   <= 1'b0;
      link_data_r <= 8'h00;
      halted_r    <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= '0;
      jump_r      <= 8'h00;
      alu_r       <= 8'h00;
    end else begin
      pc_r        <= pc_nxt_s;
      instr_r     <= instr_nxt_s;
      req_r       <= req_nxt_s;
      ivalid_r    <= ivalid_nxt_s;
      link_we_r   <= link_we_nxt_s;
      link_data_r <= link_data_nxt_s;
      halted_r    <= halted_nxt_s;
      err_r       <= err_nxt_s;
      cnt_r       <= cnt_nxt_s;
      jump_r      <= jump_nxt_s;
      alu_r       <= alu_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// instruction streams checked against a transaction-level PC model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n, imem_ack, ack2, exec_done;
  logic [7:0] imem_data, jump, alu_out;

  logic       imem_req, instr_valid, link_we, halted, fetch_err;
  logic [7:0] imem_addr, instr, pc, link_data;

  logic       to_req, to_ivalid, to_link_we, to_halted, to_err;
  logic [7:0] to_addr, to_instr, to_pc, to_link_data;

  int total = 0;
  int bad   = 0;
  int exp_pc;

  fetch_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .pc(pc),
    .instr_valid(instr_valid), .exec_done(exec_done), .jump(jump),
    .alu_out(alu_out), .link_we(link_we), .link_data(link_data),
    .halted(halted), .fetch_err(fetch_err)
  );

  fetch_sequencer #(.RESET_PC(8'h00), .ACK_TIMEOUT(3)) u_dut_to (
    .clk(clk), .rst_n(rst2_n), .imem_req(to_req), .imem_addr(to_addr),
    .imem_ack(ack2), .imem_data(imem_data), .instr(to_instr), .pc(to_pc),
    .instr_valid(to_ivalid), .exec_done(exec_done), .jump(jump),
    .alu_out(alu_out), .link_we(to_link_we), .link_data(to_link_data),
    .halted(to_halted), .fetch_err(to_err)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_req",    {7'd0, imem_req}, 8'h00);
    chk("rst_addr",   imem_addr, 8'h00);
    chk("rst_pc",     pc, 8'h00);
    chk("rst_instr",  instr, 8'h00);
    chk("rst_ivalid", {7'd0, instr_valid}, 8'h00);
    chk("rst_linkwe", {7'd0, link_we}, 8'h00);
    chk("rst_linkd",  link_data, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);
    chk("rst_err",    {7'd0, fetch_err}, 8'h00);
    tick();
    rst_n  = 1'b1;
    exp_pc = 0;
  endtask

  // One full instruction: fetch with ack_wait idle cycles, execute with
  // exec_wait idle cycles, then check the update against the model.
  task automatic run_instr(input logic [7:0] ins, input logic [7:0] j, input logic [7:0] a,
                           input int ack_wait, input int exec_wait, output bit hit_halt);
    int  op, imm, tgt;
    bit  taken, jal;
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    chk("req_up", {7'd0, imem_req}, 8'h01);
    chk("fetch_addr", imem_addr, 8'(exp_pc));
    for (int i = 0; i < ack_wait; i++) begin
      imem_ack = 1'b0;
      tick();
      chk("req_hold", {7'd0, imem_req}, 8'h01);
      chk("addr_hold", imem_addr, 8'(exp_pc));
    end
    imem_ack  = 1'b1;
    imem_data = ins;
    tick();
    imem_ack  = 1'b0;
    imem_data = 8'($urandom);
    chk("ivalid_up", {7'd0, instr_valid}, 8'h01);
    chk("instr", instr, ins);
    chk("exec_pc", pc, 8'(exp_pc));
    chk("req_drop", {7'd0, imem_req}, 8'h00);
    for (int i = 0; i < exec_wait; i++) begin
      exec_done = 1'b0;
      jump      = 8'($urandom);
      alu_out   = 8'($urandom);
      tick();
      chk("ivalid_hold", {7'd0, instr_valid}, 8'h01);
      chk("instr_hold", instr, ins);
    end
    exec_done = 1'b1;
    jump      = j;
    alu_out   = a;
    tick();
    exec_done = 1'b0;
    jump      = 8'($urandom);
    alu_out   = 8'($urandom);

    // Reference model: next PC from the instruction-level rules.
    taken = (j == 8'hFF);
    op    = int'(ins) / 16;
    imm   = int'(ins) % 16;
    if (imm > 7) imm = imm - 16;
    tgt = exp_pc + 1;
    if (taken && (op == 8 || op == 9)) tgt = exp_pc + 1 + int'(a);
    if (taken && (op == 12 || op == 13)) tgt = exp_pc + 1 + imm;
    tgt      = tgt & 255;
    jal      = taken && (op == 9);
    hit_halt = taken && (tgt == exp_pc);

    chk("link_we", {7'd0, link_we}, {7'd0, jal});
    if (jal) chk("link_data", link_data, 8'((exp_pc + 1) & 255));
    chk("ivalid_drop", {7'd0, instr_valid}, 8'h00);
    tick();
    chk("link_pulse", {7'd0, link_we}, 8'h00);
    chk("halted", {7'd0, halted}, {7'd0, hit_halt});
    chk("no_err", {7'd0, fetch_err}, 8'h00);
    if (hit_halt) begin
      for (int i = 0; i < 3; i++) begin
        chk("halt_noreq", {7'd0, imem_req}, 8'h00);
        chk("halt_noval", {7'd0, instr_valid}, 8'h00);
        tick();
      end
      chk("halt_sticky", {7'd0, halted}, 8'h01);
    end else begin
      chk("next_req", {7'd0, imem_req}, 8'h01);
      chk("next_addr", imem_addr, 8'(tgt));
      exp_pc = tgt;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit h;
    logic [7:0] rj;
    rst_n = 1'b0; rst2_n = 1'b0; imem_ack = 1'b0; ack2 = 1'b0; exec_done = 1'b0;
    imem_data = 8'h00; jump = 8'h00; alu_out = 8'h00;
    tick();
    do_reset();

    // Directed walk through the documented scenarios.
    run_instr(8'h12, 8'h00, 8'h00, 0, 0, h);
    run_instr(8'h80, 8'hFF, 8'hFD, 1, 1, h);   // to pc FF
    run_instr(8'h34, 8'h00, 8'h00, 0, 2, h);   // FF wraps to 00
    run_instr(8'h80, 8'hFF, 8'h0F, 2, 0, h);   // to pc 10
    run_instr(8'h93, 8'hFF, 8'h05, 0, 1, h);   // JAL: link 11, pc 16
    run_instr(8'h80, 8'hFF, 8'h09, 0, 0, h);   // to pc 20
    run_instr(8'hCE, 8'hFF, 8'h00, 1, 0, h);   // 20 -> 1F
    run_instr(8'h80, 8'hFF, 8'h00, 0, 0, h);   // 1F -> 20
    run_instr(8'hCE, 8'h01, 8'h00, 0, 1, h);   // not taken: 20 -> 21
    run_instr(8'h80, 8'hFF, 8'hFF, 0, 0, h);   // self-jump halts
    chk("halt_seen", {7'd0, halted}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("halt_async_clr", {7'd0, halted}, 8'h00);
    tick();
    do_reset();

    // Random instruction stream.
    for (int n = 0; n < 60; n++) begin
      rj = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      run_instr(8'($urandom), rj, 8'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), h);
      if (h) do_reset();
    end

    // Ack timeout on the ACK_TIMEOUT=3 instance.
    rst2_n = 1'b0;
    tick();
    rst2_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_req_wait", {7'd0, to_req}, 8'h01);
      chk("to_err_wait", {7'd0, to_err}, 8'h00);
    end
    tick();
    chk("to_req_drop", {7'd0, to_req}, 8'h00);
    chk("to_err_set", {7'd0, to_err}, 8'h01);
    tick();
    tick();
    chk("to_err_sticky", {7'd0, to_err}, 8'h01);
    chk("to_req_off", {7'd0, to_req}, 8'h00);
    chk("to_ivalid", {7'd0, to_ivalid}, 8'h00);
    chk("to_halted", {7'd0, to_halted}, 8'h00);
    chk("to_link_we", {7'd0, to_link_we}, 8'h00);
    chk("to_pc", to_pc, 8'h00);
    chk("to_addr", to_addr, 8'h00);
    chk("to_instr", to_instr, 8'h00);
    chk("to_link_data", to_link_data, 8'h00);

    // Reset asserted mid-FETCH drops req at once.
    rst2_n = 1'b0;
    tick();
    chk("to_err_clr", {7'd0, to_err}, 8'h00);
    rst2_n = 1'b1;
    tick();
    tick();
    chk("to_req_mid", {7'd0, to_req}, 8'h01);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("to_req_async", {7'd0, to_req}, 8'h00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
